// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter_if
// Description : Bundle of the requester-side and register-side signals of
//               reg_write_arbiter. The slave modport is the arbiter; the
//               master modport is the surrounding requesters plus register.
//               The lock vector exists only when REGARB_LOCK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   ack;
  logic [W-1:0]   rdata;
  logic [W-1:0]   reg_d;
  logic           reg_load;
  logic [W-1:0]   reg_q;
  logic [IDW-1:0] grant_id;
  logic           busy;
`ifdef REGARB_LOCK_EN
  logic [N-1:0]   lock;
`endif

  modport slave (
`ifdef REGARB_LOCK_EN
    input  lock,
`endif
    input  req, wdata, reg_q,
    output ack, rdata, reg_d, reg_load, grant_id, busy
  );

  modport master (
`ifdef REGARB_LOCK_EN
    output lock,
`endif
    output req, wdata, reg_q,
    input  ack, rdata, reg_d, reg_load, grant_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin controller sharing one W-bit register among N
//               requesters. Each write runs IDLE -> LOAD -> SETTLE -> ACK:
//               grant, one-cycle load strobe, SETTLE_CYC wait, then readback
//               of the register q with a one-cycle one-hot ack.
//               Optional macro REGARB_LOCK_EN adds a per-requester lock that
//               keeps the round-robin pointer on the current winner.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter #(
  parameter int N          = 4,
  parameter int W          = 8,
  parameter int SETTLE_CYC = 1
) (
  input  wire                    clk,
  input  wire                    rst,
  reg_write_arbiter_if.slave     bus_io
);

  localparam int IDW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]     c_SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [IDW-1:0] c_LAST_ID     = IDW'(N - 1);

  // Reject illegal configurations at elaboration time.
  generate
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
      $error("reg_write_arbiter: SETTLE_CYC must be in 1..15");
    end
    if (N < 2 || N > 8) begin : g_bad_n
      $error("reg_write_arbiter: N must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_ACK    = 2'd3
  } state_t;

  state_t         state_q;
  logic [IDW-1:0] ptr_q;
  logic [3:0]     cnt_q;
  logic [IDW-1:0] grant_id_q;
  logic [W-1:0]   reg_d_q;
  logic           reg_load_q;
  logic [N-1:0]   ack_q;
  logic [W-1:0]   rdata_q;
  logic           busy_q;

  logic [IDW-1:0] pick_d;
  logic           pick_vld_d;
  logic [IDW-1:0] ptr_adv_d;
  logic [IDW-1:0] ptr_next_d;

  // Round-robin search: first set req bit at or above the pointer, wrapping.
  // Scanning offsets from high to low lets the smallest offset win.
  always_comb begin
    pick_d     = '0;
    pick_vld_d = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(ptr_q) + k) % N);
      if (bus_io.req[idx]) begin
        pick_d     = idx;
        pick_vld_d = 1'b1;
      end
    end
  end

  // Pointer value after the current grant: next requester, wrapping to 0.
  always_comb begin
    ptr_adv_d = (grant_id_q == c_LAST_ID) ? '0 : grant_id_q + 1'b1;
`ifdef REGARB_LOCK_EN
    ptr_next_d = bus_io.lock[grant_id_q] ? grant_id_q : ptr_adv_d;
`else
    ptr_next_d = ptr_adv_d;
`endif
  end

  // Transaction sequencer; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      grant_id_q <= '0;
      reg_d_q    <= '0;
      reg_load_q <= 1'b0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            grant_id_q <= pick_d;
            reg_d_q    <= bus_io.wdata[int'(pick_d) * W +: W];
            reg_load_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          reg_load_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == c_SETTLE_LAST) begin
            rdata_q            <= bus_io.reg_q;
            ack_q[grant_id_q]  <= 1'b1;
            state_q            <= S_ACK;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_ACK: begin
          ack_q   <= '0;
          ptr_q   <= ptr_next_d;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.ack      = ack_q;
  assign bus_io.rdata    = rdata_q;
  assign bus_io.reg_d    = reg_d_q;
  assign bus_io.reg_load = reg_load_q;
  assign bus_io.grant_id = grant_id_q;
  assign bus_io.busy     = busy_q;

endmodule
`default_nettype wire
